// File: rtl/dcache_pkg.sv
// Shared types and geometry for the data-cache tag controller.
package dcache_pkg;

    localparam int SETS     = 128;
    localparam int TAG_W    = 20;
    localparam int LINE_OFF = 5;
    localparam int IDX_W    = $clog2(SETS);

    localparam logic COP_IDX_INV = 1'b0;
    localparam logic COP_HIT_INV = 1'b1;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        FILL,
        COP_RD,
        COP_WR
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/dcache_perf_cnt.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module dcache_perf_cnt (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = sat_inc(count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dcache_tag_ctrl.sv
// Data-cache tag controller: array clear, lookup, miss refill and cache-op invalidation.
// Define DCACHE_TAG_CTRL_PERF_EN to build the saturating hit/miss counters.
module dcache_tag_ctrl
    import dcache_pkg::*;
#(
    parameter int SETS     = dcache_pkg::SETS,
    parameter int TAG_W    = dcache_pkg::TAG_W,
    parameter int LINE_OFF = dcache_pkg::LINE_OFF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     resp_valid,
    output logic                     resp_hit,
    input  logic                     cop_valid,
    output logic                     cop_ready,
    input  logic                     cop_type,
    input  logic [31:0]              cop_addr,
    output logic                     cop_done,
    output logic                     refill_valid,
    input  logic                     refill_ready,
    output logic [31:0]              refill_addr,
    input  logic                     refill_done,
    output logic                     tag_en,
    output logic                     tag_wen,
    output logic [$clog2(SETS)-1:0]  tag_index,
    output logic [TAG_W:0]           tag_wdata,
    input  logic [TAG_W:0]           tag_rdata,
    output logic                     init_busy,
    output logic [31:0]              perf_hit,
    output logic [31:0]              perf_miss
);

    localparam int IW = $clog2(SETS);

    state_e              state_q, state_d;
    logic [IW-1:0]       clr_idx_q, clr_idx_d;
    logic [31:LINE_OFF]  addr_q, addr_d;
    logic                resp_hit_q, resp_hit_d;
    logic                cop_match_q, cop_match_d;

    tag_entry_t          rd_entry;
    logic                rd_match;
    logic                unused_addr_bits;

    assign rd_entry = tag_rdata;
    assign rd_match = rd_entry.valid && (rd_entry.tag == addr_q[31 -: TAG_W]);

    // Byte-offset bits never reach the tag array.
    assign unused_addr_bits = ^{req_addr[LINE_OFF-1:0], cop_addr[LINE_OFF-1:0]};

    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        addr_d       = addr_q;
        resp_hit_d   = 1'b0;
        cop_match_d  = cop_match_q;
        req_ready    = 1'b0;
        cop_ready    = 1'b0;
        cop_done     = 1'b0;
        refill_valid = 1'b0;
        refill_addr  = {addr_q, {LINE_OFF{1'b0}}};
        tag_en       = 1'b0;
        tag_wen      = 1'b0;
        tag_index    = addr_q[LINE_OFF +: IW];
        tag_wdata    = '0;
        init_busy    = 1'b0;
        resp_valid   = resp_hit_q;
        resp_hit     = resp_hit_q;

        unique case (state_q)
            INIT: begin
                init_busy = 1'b1;
                tag_en    = 1'b1;
                tag_wen   = 1'b1;
                tag_index = clr_idx_q;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IW'(SETS - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                // A pending cache-op wins, so the lookup is not acknowledged this cycle.
                cop_ready = 1'b1;
                req_ready = !cop_valid;
                if (cop_valid) begin
                    addr_d = cop_addr[31:LINE_OFF];
                    if (cop_type == COP_HIT_INV) begin
                        tag_en    = 1'b1;
                        tag_index = cop_addr[LINE_OFF +: IW];
                        state_d   = COP_RD;
                    end else begin
                        cop_match_d = 1'b1;
                        state_d     = COP_WR;
                    end
                end else if (req_valid) begin
                    addr_d    = req_addr[31:LINE_OFF];
                    tag_en    = 1'b1;
                    tag_index = req_addr[LINE_OFF +: IW];
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (rd_match) begin
                    resp_hit_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                refill_valid = 1'b1;
                if (refill_ready) begin
                    state_d = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (refill_done) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                tag_en     = 1'b1;
                tag_wen    = 1'b1;
                tag_wdata  = {1'b1, addr_q[31 -: TAG_W]};
                resp_valid = 1'b1;
                resp_hit   = 1'b0;
                state_d    = IDLE;
            end
            COP_RD: begin
                cop_match_d = rd_match;
                state_d     = COP_WR;
            end
            COP_WR: begin
                tag_en   = cop_match_q;
                tag_wen  = cop_match_q;
                cop_done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase

        // While reset is held nothing may be written or handshaken.
        if (!resetn) begin
            req_ready    = 1'b0;
            cop_ready    = 1'b0;
            cop_done     = 1'b0;
            refill_valid = 1'b0;
            refill_addr  = '0;
            tag_en       = 1'b0;
            tag_wen      = 1'b0;
            tag_index    = '0;
            tag_wdata    = '0;
            resp_valid   = 1'b0;
            resp_hit     = 1'b0;
            init_busy    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= INIT;
            clr_idx_q   <= '0;
            addr_q      <= '0;
            resp_hit_q  <= 1'b0;
            cop_match_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            addr_q      <= addr_d;
            resp_hit_q  <= resp_hit_d;
            cop_match_q <= cop_match_d;
        end
    end

`ifdef DCACHE_TAG_CTRL_PERF_EN
    dcache_perf_cnt u_perf_hit (
        .clk    (clk),
        .resetn (resetn),
        .inc    (resp_valid & resp_hit),
        .count  (perf_hit)
    );

    dcache_perf_cnt u_perf_miss (
        .clk    (clk),
        .resetn (resetn),
        .inc    (resp_valid & ~resp_hit),
        .count  (perf_miss)
    );
`else
    assign perf_hit  = '0;
    assign perf_miss = '0;
`endif

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Directed self-checking bench for dcache_tag_ctrl with a behavioural tag RAM.
module tb_dcache_tag_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_hit;
    logic        cop_valid;
    logic        cop_ready;
    logic        cop_type;
    logic [31:0] cop_addr;
    logic        cop_done;
    logic        refill_valid;
    logic        refill_ready;
    logic [31:0] refill_addr;
    logic        refill_done;
    logic        tag_en;
    logic        tag_wen;
    logic [6:0]  tag_index;
    logic [20:0] tag_wdata;
    logic [20:0] tag_rdata = '0;
    logic        init_busy;
    logic [31:0] perf_hit;
    logic [31:0] perf_miss;

    always #5 clk = ~clk;

    dcache_tag_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .cop_valid    (cop_valid),
        .cop_ready    (cop_ready),
        .cop_type     (cop_type),
        .cop_addr     (cop_addr),
        .cop_done     (cop_done),
        .refill_valid (refill_valid),
        .refill_ready (refill_ready),
        .refill_addr  (refill_addr),
        .refill_done  (refill_done),
        .tag_en       (tag_en),
        .tag_wen      (tag_wen),
        .tag_index    (tag_index),
        .tag_wdata    (tag_wdata),
        .tag_rdata    (tag_rdata),
        .init_busy    (init_busy),
        .perf_hit     (perf_hit),
        .perf_miss    (perf_miss)
    );

    // Tag RAM with one-cycle read latency, preloaded with garbage so the clear is visible.
    logic [20:0] mem [128] = '{default: 21'h1F_FFFF};
    int          init_wr_cnt    = 0;
    int          init_order_err = 0;
    int          resp_cnt       = 0;
    int          cop_done_cnt   = 0;
    logic [6:0]  init_exp_idx   = '0;

    always @(posedge clk) begin
        if (!resetn) begin
            init_exp_idx   <= '0;
            init_wr_cnt    <= 0;
            init_order_err <= 0;
        end else if (tag_en && tag_wen && init_busy) begin
            if (tag_index != init_exp_idx || tag_wdata != 21'h0) init_order_err <= init_order_err + 1;
            init_exp_idx <= init_exp_idx + 7'd1;
            init_wr_cnt  <= init_wr_cnt + 1;
        end
        if (resp_valid) resp_cnt <= resp_cnt + 1;
        if (cop_done) cop_done_cnt <= cop_done_cnt + 1;
        if (tag_en && tag_wen) mem[tag_index] <= tag_wdata;
        else if (tag_en) tag_rdata <= mem[tag_index];
    end

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_init(input string tag);
        int cyc = 0;
        int rdy_seen = 0;
        int nz = 0;
        #1;
        while (init_busy === 1'b1 && cyc < 400) begin
            if (req_ready !== 1'b0 || cop_ready !== 1'b0) rdy_seen++;
            cyc++;
            tick();
        end
        check({tag, "_busy_cycles"}, cyc, 128);
        check({tag, "_ready_seen"}, rdy_seen, 0);
        check({tag, "_writes"}, init_wr_cnt, 128);
        check({tag, "_order_err"}, init_order_err, 0);
        for (int i = 0; i < 128; i++) if (mem[i] !== 21'h0) nz++;
        check({tag, "_nonzero_entries"}, nz, 0);
    endtask

    task automatic miss_seq(input string tag, input logic [31:0] addr, input logic [6:0] idx,
                            input logic [31:0] rf_addr, input logic [20:0] entry, input int hold);
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_rd_en"}, tag_en, 1);
        check({tag, "_rd_wen"}, tag_wen, 0);
        check({tag, "_rd_idx"}, tag_index, idx);
        tick();
        req_valid = 1'b0;
        check({tag, "_lookup_resp"}, resp_valid, 0);
        tick();
        check({tag, "_refill_valid"}, refill_valid, 1);
        check({tag, "_refill_addr"}, refill_addr, rf_addr);
        for (int i = 0; i < hold; i++) begin
            refill_done = (i == 1);
            tick();
            check({tag, "_hold_valid"}, refill_valid, 1);
            check({tag, "_hold_addr"}, refill_addr, rf_addr);
            check({tag, "_hold_resp"}, resp_valid, 0);
        end
        // ready and done together: only the handshake counts
        refill_ready = 1'b1;
        refill_done  = 1'b1;
        tick();
        refill_ready = 1'b0;
        refill_done  = 1'b0;
        check({tag, "_wait_refill_valid"}, refill_valid, 0);
        check({tag, "_wait_resp"}, resp_valid, 0);
        tick();
        check({tag, "_wait2_resp"}, resp_valid, 0);
        check({tag, "_wait2_req_ready"}, req_ready, 0);
        refill_done = 1'b1;
        tick();
        refill_done = 1'b0;
        check({tag, "_fill_resp_valid"}, resp_valid, 1);
        check({tag, "_fill_resp_hit"}, resp_hit, 0);
        check({tag, "_fill_wen"}, tag_wen, 1);
        check({tag, "_fill_idx"}, tag_index, idx);
        check({tag, "_fill_wdata"}, tag_wdata, entry);
        tick();
        check({tag, "_mem_entry"}, mem[idx], entry);
        check({tag, "_post_resp"}, resp_valid, 0);
        check({tag, "_post_req_ready"}, req_ready, 1);
    endtask

    task automatic hit_seq(input string tag, input logic [31:0] addr);
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        check({tag, "_req_ready"}, req_ready, 1);
        tick();
        req_valid = 1'b0;
        check({tag, "_resp_at_1"}, resp_valid, 0);
        tick();
        check({tag, "_resp_at_2"}, resp_valid, 1);
        check({tag, "_hit_at_2"}, resp_hit, 1);
        tick();
        check({tag, "_resp_at_3"}, resp_valid, 0);
    endtask

    initial begin
        int r0;
        int c0;
        resetn       = 1'b0;
        req_valid    = 1'b0;
        req_addr     = '0;
        cop_valid    = 1'b0;
        cop_type     = 1'b0;
        cop_addr     = '0;
        refill_ready = 1'b0;
        refill_done  = 1'b0;
        tick(); tick(); tick();

        check("rst_init_busy", init_busy, 1);
        check("rst_req_ready", req_ready, 0);
        check("rst_cop_ready", cop_ready, 0);
        check("rst_tag_en", tag_en, 0);
        check("rst_tag_wen", tag_wen, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_refill_valid", refill_valid, 0);
        check("rst_cop_done", cop_done, 0);
        check("rst_perf_hit", perf_hit, 0);
        check("rst_perf_miss", perf_miss, 0);

        // Requests held during the clear must be ignored.
        resetn    = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_1040;
        cop_valid = 1'b1;
        run_init("init1");
        req_valid = 1'b0;
        cop_valid = 1'b0;
        #1;
        check("idle_req_ready", req_ready, 1);
        check("idle_resp_none", resp_cnt, 0);

        // Cold miss at 0x1040: index 2, tag 0x00001.
        miss_seq("miss1040", 32'h0000_1040, 7'd2, 32'h0000_1040, 21'h10_0001, 5);
        hit_seq("hit1040", 32'h0000_1040);
`ifdef DCACHE_TAG_CTRL_PERF_EN
        check("perf_hit_1", perf_hit, 1);
        check("perf_miss_1", perf_miss, 1);
`else
        check("perf_hit_off", perf_hit, 0);
        check("perf_miss_off", perf_miss, 0);
`endif

        // Simultaneous cop and req: hit-invalidate on tag 5 at index 2 (no match) goes first.
        cop_valid = 1'b1;
        cop_type  = 1'b1;
        cop_addr  = 32'h0000_5040;
        req_valid = 1'b1;
        req_addr  = 32'h0000_1040;
        #1;
        check("prio_cop_ready", cop_ready, 1);
        check("prio_req_ready", req_ready, 0);
        check("prio_rd_idx", tag_index, 2);
        tick();
        cop_valid = 1'b0;
        check("hinv_nm_rd_done", cop_done, 0);
        check("hinv_nm_rd_req_ready", req_ready, 0);
        tick();
        check("hinv_nm_done", cop_done, 1);
        check("hinv_nm_wen", tag_wen, 0);
        tick();
        check("prio_req_after", req_ready, 1);
        tick();
        req_valid = 1'b0;
        check("hinv_nm_entry", mem[2], 21'h10_0001);
        tick();
        check("prio_req_resp", resp_valid, 1);
        check("prio_req_hit", resp_hit, 1);
        tick();

        // Hit-invalidate with matching tag clears index 2.
        cop_valid = 1'b1;
        cop_type  = 1'b1;
        cop_addr  = 32'h0000_1040;
        #1;
        check("hinv_m_ready", cop_ready, 1);
        tick();
        cop_valid = 1'b0;
        tick();
        check("hinv_m_wen", tag_wen, 1);
        check("hinv_m_idx", tag_index, 2);
        check("hinv_m_wdata", tag_wdata, 0);
        check("hinv_m_done", cop_done, 1);
        tick();
        check("hinv_m_entry", mem[2], 21'h0);
        check("hinv_m_done_pulse", cop_done, 0);

        // Fill index 3 then index-invalidate it with an unrelated tag.
        miss_seq("miss3060", 32'h0000_3060, 7'd3, 32'h0000_3060, 21'h10_0003, 0);
        cop_valid = 1'b1;
        cop_type  = 1'b0;
        cop_addr  = 32'hFFFF_F060;
        #1;
        check("iinv_ready", cop_ready, 1);
        tick();
        cop_valid = 1'b0;
        check("iinv_done", cop_done, 1);
        check("iinv_wen", tag_wen, 1);
        check("iinv_idx", tag_index, 3);
        check("iinv_wdata", tag_wdata, 0);
        tick();
        check("iinv_entry", mem[3], 21'h0);
        check("cop_done_total", cop_done_cnt, 3);

        // Repopulate index 2, then reset in MISS_WAIT of a miss to 0x2080 (index 4).
        miss_seq("refill1040", 32'h0000_1040, 7'd2, 32'h0000_1040, 21'h10_0001, 0);
        req_valid = 1'b1;
        req_addr  = 32'h0000_2080;
        tick();
        req_valid = 1'b0;
        tick();
        check("mw_refill_addr", refill_addr, 32'h0000_2080);
        refill_ready = 1'b1;
        tick();
        refill_ready = 1'b0;
        check("mw_in_wait", refill_valid, 0);
        r0 = resp_cnt;
        c0 = cop_done_cnt;
        resetn      = 1'b0;
        refill_done = 1'b1;
        #1;
        check("mw_rst_resp", resp_valid, 0);
        tick();
        check("mw_rst_busy", init_busy, 1);
        check("mw_rst_resp2", resp_valid, 0);
        check("mw_rst_perf_hit", perf_hit, 0);
        check("mw_rst_perf_miss", perf_miss, 0);
        tick();
        refill_done = 1'b0;
        resetn      = 1'b1;
        run_init("init2");
        check("mw_no_resp", resp_cnt, r0);
        check("mw_no_cop_done", cop_done_cnt, c0);
        check("mw_perf_hit", perf_hit, 0);
        check("mw_perf_miss", perf_miss, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
